// File: rtl/hssi_bw_mode_seq_pkg.sv
// Shared HSSI configuration types: bandwidth modes, sequencer states and error codes,
// plus helpers that map a bandwidth mode onto the raw lanes it occupies.
package hssi_bw_mode_seq_pkg;

    typedef enum logic [4:0] {
        BW_NONE  = 5'h00,
        BW_10G   = 5'h01,
        BW_4X10G = 5'h02,
        BW_40G   = 5'h04,
        BW_2X40G = 5'h08,
        BW_100G  = 5'h10
    } bw_mode_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'd0,
        ERR_UNSUPPORTED = 2'd1,
        ERR_TIMEOUT     = 2'd2
    } done_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_WAIT_LOCK,
        ST_RESP
    } seq_state_e;

    // Non-one-hot codes map to an empty mask.
    function automatic logic [7:0] lane_mask(input logic [4:0] mode);
        logic [7:0] m;
        case (mode)
            BW_10G:                    m = 8'h01;
            BW_4X10G, BW_40G, BW_100G: m = 8'h0F;
            BW_2X40G:                  m = 8'hFF;
            default:                   m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic int lane_count(input logic [4:0] mode);
        logic [7:0] m;
        int         n;
        m = lane_mask(mode);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(m[i]);
        end
        return n;
    endfunction

    function automatic logic is_onehot(input logic [4:0] mode);
        return (mode != 5'd0) && ((mode & (mode - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/hssi_bw_mode_seq_timer.sv
// Loadable down-counter that parks at zero; expired is a plain decode of zero.
module hssi_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/hssi_bw_mode_seq.sv
// HSSI bandwidth-mode change sequencer: validate, hold lanes in reset, wait for lock, report.
//   state        | meaning
//   ST_IDLE      | ready for a request; cur_mode/link_up reflect the committed mode
//   ST_RST_HOLD  | all lanes in reset, new mode on cfg_mode, hold timer running
//   ST_WAIT_LOCK | active lanes released, waiting for all of them to report ready
//   ST_RESP      | one-cycle done_valid with done_err
module hssi_bw_mode_seq
    import hssi_bw_mode_seq_pkg::*;
#(
    parameter int         NUM_LANES           = 4,
    parameter logic [4:0] BW_MODES            = 5'h1F,
    parameter int         RESET_HOLD_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [4:0]           req_mode,
    output logic                 req_ready,
    input  logic [NUM_LANES-1:0] lane_ready,
    output logic [NUM_LANES-1:0] lane_rst,
    output logic [4:0]           cfg_mode,
    output logic [4:0]           cur_mode,
    output logic                 link_up,
    output logic                 done_valid,
    output logic [1:0]           done_err
);

    localparam int TMR_MAX = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    // The timer reads zero in the last cycle of each phase, hence the minus one.
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);

    function automatic logic [NUM_LANES-1:0] fit_mask(input logic [7:0] m);
        logic [NUM_LANES-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i < 8) r[i] = m[i[2:0]];
        end
        return r;
    endfunction

    seq_state_e           r_state, w_state_nxt;
    logic [4:0]           r_mode, w_mode_nxt;
    logic [4:0]           r_cfg_mode, w_cfg_mode_nxt;
    logic [4:0]           r_cur_mode, w_cur_mode_nxt;
    logic [NUM_LANES-1:0] r_lane_rst, w_lane_rst_nxt;
    done_err_e            r_done_err, w_done_err_nxt;
    logic                 r_link_up;

    logic                 w_tmr_load;
    logic [TMR_W-1:0]     w_tmr_val;
    logic                 w_tmr_expired;
    logic                 w_unsupported;
    logic [NUM_LANES-1:0] w_act_mask;
    logic [NUM_LANES-1:0] w_cur_mask;

    assign w_act_mask    = fit_mask(lane_mask(r_mode));
    assign w_cur_mask    = fit_mask(lane_mask(r_cur_mode));
    assign w_unsupported = !is_onehot(req_mode)
                         || ((req_mode & BW_MODES) == 5'd0)
                         || (lane_count(req_mode) > NUM_LANES);

    hssi_seq_timer #(.W(TMR_W)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 5'd0;
            r_cfg_mode <= 5'd0;
            r_cur_mode <= 5'd0;
            r_lane_rst <= '1;
            r_done_err <= ERR_OK;
            r_link_up  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_cfg_mode <= w_cfg_mode_nxt;
            r_cur_mode <= w_cur_mode_nxt;
            r_lane_rst <= w_lane_rst_nxt;
            r_done_err <= w_done_err_nxt;
            r_link_up  <= (r_cur_mode != 5'd0) && ((lane_ready & w_cur_mask) == w_cur_mask);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_cfg_mode_nxt = r_cfg_mode;
        w_cur_mode_nxt = r_cur_mode;
        w_lane_rst_nxt = r_lane_rst;
        w_done_err_nxt = r_done_err;
        w_tmr_load     = 1'b0;
        w_tmr_val      = HOLD_LOAD;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_unsupported) begin
                        w_state_nxt    = ST_RESP;
                        w_done_err_nxt = ERR_UNSUPPORTED;
                    end else if ((req_mode == r_cur_mode) && r_link_up) begin
                        w_state_nxt    = ST_RESP;
                        w_done_err_nxt = ERR_OK;
                    end else begin
                        w_state_nxt    = ST_RST_HOLD;
                        w_mode_nxt     = req_mode;
                        w_cfg_mode_nxt = req_mode;
                        w_lane_rst_nxt = '1;
                        w_cur_mode_nxt = 5'd0;
                        w_tmr_load     = 1'b1;
                        w_tmr_val      = HOLD_LOAD;
                    end
                end
            end
            ST_RST_HOLD: begin
                if (w_tmr_expired) begin
                    w_state_nxt    = ST_WAIT_LOCK;
                    w_lane_rst_nxt = ~w_act_mask;
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = LOCK_LOAD;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a same-cycle timeout.
                if ((lane_ready & w_act_mask) == w_act_mask) begin
                    w_state_nxt    = ST_RESP;
                    w_done_err_nxt = ERR_OK;
                    w_cur_mode_nxt = r_mode;
                end else if (w_tmr_expired) begin
                    w_state_nxt    = ST_RESP;
                    w_done_err_nxt = ERR_TIMEOUT;
                    w_lane_rst_nxt = '1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign done_valid = (r_state == ST_RESP);
    assign done_err   = r_done_err;
    assign lane_rst   = r_lane_rst;
    assign cfg_mode   = r_cfg_mode;
    assign cur_mode   = r_cur_mode;
    assign link_up    = r_link_up;

endmodule

// File: tb/tb_hssi_bw_mode_seq.sv
// Bench for hssi_bw_mode_seq: directed scenarios plus randomized requests against a mode-rule model.
module tb_hssi_bw_mode_seq;

    localparam int         NL  = 4;
    localparam logic [4:0] BWM = 5'h07;
    localparam int         RH  = 4;
    localparam int         TO  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic [4:0]    req_mode;
    logic          req_ready;
    logic [NL-1:0] lane_ready;
    logic [NL-1:0] lane_rst;
    logic [4:0]    cfg_mode;
    logic [4:0]    cur_mode;
    logic          link_up;
    logic          done_valid;
    logic [1:0]    done_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]    m_cur;
    logic [4:0]    m_cfg;
    logic [NL-1:0] m_lane_rst;
    logic          m_link;

    always #5 clk = ~clk;

    hssi_bw_mode_seq #(
        .NUM_LANES          (NL),
        .BW_MODES           (BWM),
        .RESET_HOLD_CYCLES  (RH),
        .LOCK_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .lane_ready(lane_ready),
        .lane_rst  (lane_rst),
        .cfg_mode  (cfg_mode),
        .cur_mode  (cur_mode),
        .link_up   (link_up),
        .done_valid(done_valid),
        .done_err  (done_err)
    );

    // Lanes needed per mode bit: 10G, 4x10G, 40G, 2x40G, 100G.
    function automatic int needed_lanes(input logic [4:0] mode);
        int tbl [5] = '{1, 4, 4, 8, 4};
        for (int i = 0; i < 5; i++) begin
            if (mode == (5'd1 << i)) return tbl[i];
        end
        return 0;
    endfunction

    function automatic logic [NL-1:0] model_mask(input logic [4:0] mode);
        int         n;
        logic [7:0] m;
        n = needed_lanes(mode);
        m = 8'((1 << n) - 1);
        return m[NL-1:0];
    endfunction

    function automatic logic model_unsupported(input logic [4:0] mode);
        logic [4:0] offered;
        offered = BWM;
        if ($countones(mode) != 1) return 1'b1;
        if ((mode & offered) == 5'd0) return 1'b1;
        if (needed_lanes(mode) > NL) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic send(input logic [4:0] mode);
        req_valid = 1'b1;
        req_mode  = mode;
        @(negedge clk);
        req_valid = 1'b0;
        req_mode  = 5'd0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid  = 1'b0;
        req_mode   = 5'd0;
        lane_ready = '0;
        apply_reset();
        n_checks++;
        if (lane_rst !== 4'hF) begin
            n_errors++; $display("FAIL reset_lane_rst: got %h expected F", lane_rst);
        end
        n_checks++;
        if (cur_mode !== 5'd0 || cfg_mode !== 5'd0) begin
            n_errors++; $display("FAIL reset_modes: got cur %h cfg %h expected 0 0", cur_mode, cfg_mode);
        end
        n_checks++;
        if (req_ready !== 1'b1 || done_valid !== 1'b0 || link_up !== 1'b0 || done_err !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_flags: got ready %b done %b link %b err %0d expected 1 0 0 0",
                     req_ready, done_valid, link_up, done_err);
        end
    endtask

    task automatic test_full_path();
        int bad;
        lane_ready = '0;
        send(5'h02);
        bad = 0;
        for (int k = 1; k <= RH; k++) begin
            if (lane_rst !== 4'hF || cfg_mode !== 5'h02 || req_ready !== 1'b0 || done_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL full_hold_window: got %0d bad cycles expected 0", bad);
        end
        n_checks++;
        if (lane_rst !== 4'h0) begin
            n_errors++; $display("FAIL full_release: got lane_rst %h expected 0 at T+5", lane_rst);
        end
        lane_ready = 4'hF;
        tick();
        n_checks++;
        if (done_valid !== 1'b1 || done_err !== 2'd0 || cur_mode !== 5'h02 || link_up !== 1'b0) begin
            n_errors++;
            $display("FAIL full_done: got done %b err %0d cur %h link %b expected 1 0 02 0",
                     done_valid, done_err, cur_mode, link_up);
        end
        tick();
        n_checks++;
        if (link_up !== 1'b1 || done_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_link_up: got link %b done %b ready %b expected 1 0 1",
                     link_up, done_valid, req_ready);
        end
    endtask

    task automatic test_unsupported();
        logic [4:0]    modes [3] = '{5'h10, 5'h08, 5'h03};
        logic [NL-1:0] p_rst;
        logic [4:0]    p_cfg, p_cur;
        for (int i = 0; i < 3; i++) begin
            p_rst = lane_rst; p_cfg = cfg_mode; p_cur = cur_mode;
            send(modes[i]);
            n_checks++;
            if (done_valid !== 1'b1 || done_err !== 2'd1) begin
                n_errors++;
                $display("FAIL unsup_%h_resp: got done %b err %0d expected 1 1", modes[i], done_valid, done_err);
            end
            n_checks++;
            if (lane_rst !== p_rst || cfg_mode !== p_cfg || cur_mode !== p_cur) begin
                n_errors++;
                $display("FAIL unsup_%h_outputs: got rst %h cfg %h cur %h expected %h %h %h",
                         modes[i], lane_rst, cfg_mode, cur_mode, p_rst, p_cfg, p_cur);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int pulses;
        lane_ready = '0;
        tick();
        send(5'h01);
        repeat (RH) tick();
        n_checks++;
        if (lane_rst !== 4'hE || cur_mode !== 5'd0 || cfg_mode !== 5'h01) begin
            n_errors++;
            $display("FAIL timeout_wait: got rst %h cur %h cfg %h expected E 00 01", lane_rst, cur_mode, cfg_mode);
        end
        pulses = 0;
        for (int k = RH + 2; k <= RH + TO; k++) begin
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_errors++; $display("FAIL timeout_early: got %0d early pulses expected 0", pulses);
        end
        tick();
        n_checks++;
        if (done_valid !== 1'b1 || done_err !== 2'd2 || lane_rst !== 4'hF || cur_mode !== 5'd0 || cfg_mode !== 5'h01) begin
            n_errors++;
            $display("FAIL timeout_done: got done %b err %0d rst %h cur %h cfg %h expected 1 2 F 00 01",
                     done_valid, done_err, lane_rst, cur_mode, cfg_mode);
        end
        tick();
    endtask

    task automatic test_same_mode_and_drop();
        lane_ready = 4'hF;
        send(5'h02);
        repeat (RH + 1) tick();
        tick();
        n_checks++;
        if (link_up !== 1'b1 || cur_mode !== 5'h02) begin
            n_errors++; $display("FAIL same_setup: got link %b cur %h expected 1 02", link_up, cur_mode);
        end
        send(5'h02);
        n_checks++;
        if (done_valid !== 1'b1 || done_err !== 2'd0 || lane_rst !== 4'h0) begin
            n_errors++;
            $display("FAIL same_resp: got done %b err %0d rst %h expected 1 0 0", done_valid, done_err, lane_rst);
        end
        tick();
        n_checks++;
        if (lane_rst !== 4'h0 || req_ready !== 1'b1 || link_up !== 1'b1) begin
            n_errors++;
            $display("FAIL same_after: got rst %h ready %b link %b expected 0 1 1", lane_rst, req_ready, link_up);
        end
        lane_ready = 4'hB;
        tick();
        n_checks++;
        if (link_up !== 1'b0 || cur_mode !== 5'h02) begin
            n_errors++; $display("FAIL drop: got link %b cur %h expected 0 02", link_up, cur_mode);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int cyc;
        lane_ready = '0;
        tick();
        send(5'h04);
        repeat (RH) tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (lane_rst !== 4'hF || cfg_mode !== 5'd0 || cur_mode !== 5'd0 || link_up !== 1'b0 ||
            done_valid !== 1'b0 || done_err !== 2'd0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_values: got rst %h cfg %h cur %h link %b done %b err %0d ready %b",
                     lane_rst, cfg_mode, cur_mode, link_up, done_valid, done_err, req_ready);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        lane_ready = 4'hF;
        send(5'h04);
        cyc = 1;
        while (done_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != RH + 2 || done_err !== 2'd0 || cur_mode !== 5'h04) begin
            n_errors++;
            $display("FAIL abort_recover: got done at T+%0d err %0d cur %h expected T+%0d 0 04",
                     cyc, done_err, cur_mode, RH + 2);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0]    mode;
        logic [NL-1:0] mask, lr;
        logic          locked;
        int            d, bad;
        lane_ready = '0;
        apply_reset();
        m_cur = 5'd0; m_cfg = 5'd0; m_lane_rst = 4'hF; m_link = 1'b0;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       mode = 5'($urandom_range(0, 31));
                1:       mode = (m_cur != 5'd0) ? m_cur : 5'h02;
                default: mode = 5'd1 << $urandom_range(0, 4);
            endcase
            repeat ($urandom_range(0, 2)) tick();
            send(mode);
            if (model_unsupported(mode) || (mode == m_cur && m_link)) begin
                n_checks++;
                if (done_valid !== 1'b1 || done_err !== (model_unsupported(mode) ? 2'd1 : 2'd0) ||
                    lane_rst !== m_lane_rst || cur_mode !== m_cur || cfg_mode !== m_cfg) begin
                    n_errors++;
                    $display("FAIL rnd%0d_short mode %h: got done %b err %0d rst %h cur %h cfg %h expected rst %h cur %h cfg %h",
                             it, mode, done_valid, done_err, lane_rst, cur_mode, cfg_mode, m_lane_rst, m_cur, m_cfg);
                end
                tick();
            end else begin
                mask = model_mask(mode);
                bad  = 0;
                for (int k = 1; k <= RH; k++) begin
                    if (lane_rst !== 4'hF || cfg_mode !== mode || cur_mode !== 5'd0 || done_valid !== 1'b0) bad++;
                    tick();
                end
                n_checks++;
                if (bad != 0) begin
                    n_errors++; $display("FAIL rnd%0d_hold mode %h: got %0d bad cycles expected 0", it, mode, bad);
                end
                n_checks++;
                if (lane_rst !== ~mask) begin
                    n_errors++; $display("FAIL rnd%0d_release: got rst %h expected %h", it, lane_rst, ~mask);
                end
                d      = $urandom_range(0, TO + 3);
                locked = 1'b0;
                bad    = 0;
                for (int j = 0; j < TO && !locked; j++) begin
                    lr = (j == d) ? 4'hF : 4'($urandom);
                    lane_ready = lr;
                    if (done_valid !== 1'b0) bad++;
                    if ((lr & mask) == mask) locked = 1'b1;
                    tick();
                end
                m_cfg      = mode;
                m_cur      = locked ? mode : 5'd0;
                m_lane_rst = locked ? ~mask : 4'hF;
                n_checks++;
                if (bad != 0 || done_valid !== 1'b1 || done_err !== (locked ? 2'd0 : 2'd2) ||
                    cur_mode !== m_cur || lane_rst !== m_lane_rst || cfg_mode !== m_cfg) begin
                    n_errors++;
                    $display("FAIL rnd%0d_done mode %h: got early %0d done %b err %0d cur %h rst %h expected lock %b cur %h rst %h",
                             it, mode, bad, done_valid, done_err, cur_mode, lane_rst, locked, m_cur, m_lane_rst);
                end
                tick();
            end
            lr = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            lane_ready = lr;
            tick();
            tick();
            m_link = (m_cur != 5'd0) && ((lr & model_mask(m_cur)) == model_mask(m_cur));
            n_checks++;
            if (link_up !== m_link || req_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL rnd%0d_link: got link %b ready %b expected %b 1", it, link_up, req_ready, m_link);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_mode   = 5'd0;
        lane_ready = '0;
        tick();
        test_reset();
        test_full_path();
        test_unsupported();
        test_timeout();
        test_same_mode_and_drop();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hssi_bw_mode_seq.md
# hssi_bw_mode_seq

Sequences HSSI bandwidth-mode changes between the AFU and the raw HSSI lanes. It accepts one mode request at a time and validates it against the platform's offered modes and lane count. For an accepted mode it holds the lanes in reset, drives the new mode to the PHY reconfiguration input, waits for per-lane ready with a timeout, and reports the result. It sits between AFU-side HSSI configuration logic and the platform HSSI PHY wrapper.

## Interface
- NUM_LANES, default 4: raw HSSI lanes; set from the raw-lane-count platform parameter.
- BW_MODES, default 5'h1F: bit mask of offered modes, using the bandwidth-mode enum encoding.
- RESET_HOLD_CYCLES, default 16: cycles all lanes are held in reset after accept (≥1).
- LOCK_TIMEOUT_CYCLES, default 1024: maximum WAIT_LOCK cycles (≥1).
- clk  in  1  clock; all logic single-domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  mode-change request.
- req_mode  in  5  requested mode, one-hot per bandwidth-mode enum.
- req_ready  out  1  high only in IDLE.
- lane_ready  in  NUM_LANES  per-lane PHY lock/ready, synchronous to clk.
- lane_rst  out  NUM_LANES  per-lane reset to PHY, active high.
- cfg_mode  out  5  mode presented to PHY reconfiguration.
- cur_mode  out  5  committed mode; 0 = none.
- link_up  out  1  cur_mode≠0 and every active lane ready.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  2  0 OK, 1 UNSUPPORTED, 2 TIMEOUT; valid with done_valid.

## Operation
- Reset values: state IDLE; lane_rst all 1; cfg_mode 0; cur_mode 0; link_up 0; done_valid 0; done_err 0; timers 0; req_ready 1 (IDLE decode). Requests are ignored while reset_n is low.
- Active lane mask per mode:
  - 10G: lane 0.
  - 4x10G, 40G, 100G: lanes 0–3.
  - 2x40G: lanes 0–7.
- A request is **unsupported** if any of the following holds:
  - req_mode is not one-hot.
  - Its bit is clear in BW_MODES.
  - It needs more lanes than NUM_LANES.
- States: IDLE, RST_HOLD, WAIT_LOCK, RESP.
- IDLE, on accept (req_valid & req_ready):
  - Unsupported → RESP with err 1. No output other than done_* changes.
  - Same mode as cur_mode while link_up=1 → RESP with err 0. No reset is applied.
  - Otherwise → RST_HOLD. Latch mode; cfg_mode ← mode; lane_rst ← all 1; cur_mode ← 0; hold timer cleared.
- RST_HOLD: count RESET_HOLD_CYCLES cycles, then → WAIT_LOCK.
- WAIT_LOCK:
  - lane_rst ← ~mask; inactive lanes stay in reset.
  - When (lane_ready & mask) == mask in a cycle → RESP with err 0 and cur_mode ← latched mode.
  - If LOCK_TIMEOUT_CYCLES elapse first → RESP with err 2. lane_rst ← all 1, cur_mode stays 0, cfg_mode keeps the failed mode.
  - Lock takes priority if it occurs in the same cycle as the timeout.
- RESP: done_valid=1 for exactly one cycle → IDLE.
- link_up is registered from cur_mode and lane_ready. A lane drop after commit clears link_up but does not change cur_mode. Recovery is by a new request, which takes the full path because link_up=0.
- Reset asserted mid-sequence aborts immediately to reset values. No done_valid is produced for the aborted request.

## Timing
- Accept in cycle T.
- Reject or same-mode: done_valid in T+1.
- Full path:
  - lane_rst all 1 and cfg_mode new from T+1 through T+RESET_HOLD_CYCLES.
  - WAIT_LOCK begins T+RESET_HOLD_CYCLES+1, with active lanes released that cycle.
  - Lock first seen in cycle L → done_valid and cur_mode update in L+1.
  - No lock → done_valid err 2 at T+RESET_HOLD_CYCLES+LOCK_TIMEOUT_CYCLES+1.
- req_ready returns high the cycle after done_valid. Back-to-back accepts are therefore spaced ≥2 cycles.
- link_up lags lane_ready by 1 cycle.

## Structure
- Extend the shared HSSI config package with:
  - the done_err enum (OK/UNSUPPORTED/TIMEOUT);
  - the FSM state enum;
  - a lane-mask function (mode → 8-bit mask);
  - a lane-count function.
- The bandwidth-mode enum is reused from the same package.
- One sub-module, hssi_seq_timer: a loadable down-counter with an expire flag, shared by RST_HOLD and WAIT_LOCK.
- Timer width is $clog2 of the larger of RESET_HOLD_CYCLES and LOCK_TIMEOUT_CYCLES, plus 1.

## Test plan
Bench parameters: NUM_LANES=4, BW_MODES=5'h07, RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=16.
- Reset then idle → lane_rst=4'hF, cur_mode=0, req_ready=1, done_valid=0.
- req_mode=5'h02 (4x10G), lane_ready=4'hF from WAIT_LOCK start (cycle T+5) → lane_rst=4'hF for T+1..T+4, 4'h0 at T+5; done_valid err 0 and cur_mode=5'h02 at T+6; link_up at T+7.
- req_mode=5'h10 (100G, not offered), then 5'h08 (2x40G, 8 lanes) and 5'h03 (not one-hot) → each gives done_valid err 1 at T+1; lane_rst, cfg_mode and cur_mode unchanged.
- req_mode=5'h01 with lane_ready=0 → lane_rst=4'hE in WAIT_LOCK; err 2 at T+21; lane_rst=4'hF; cur_mode=0.
- Committed 5'h02 with link_up=1, re-request 5'h02 → err 0 at T+1 with no lane_rst pulse. Then drop lane_ready[2] → link_up 0 one cycle later, cur_mode still 5'h02.
- reset_n low during WAIT_LOCK → all outputs at reset values immediately and no done_valid. After release, a new request completes normally.
